// File: rtl/qos_tx_pkg.sv
// Shared types and the round-robin search helper for the QoS transmit injector.
package qos_tx_pkg;

  localparam int NUM_VC_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int MAX_VC     = 32;

  typedef logic [$clog2(NUM_VC_DEF)-1:0] vc_id_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // First set bit of mask strictly after ptr, wrapping modulo n (n <= MAX_VC).
  function automatic pick_t next_eligible(input logic [MAX_VC-1:0] mask,
                                          input int unsigned ptr,
                                          input int unsigned n);
    pick_t p;
    int unsigned c;
    p.found = 1'b0;
    p.idx   = '0;
    for (int unsigned k = 1; k <= MAX_VC; k++) begin
      c = ptr + k;
      if (c >= n) c = c - n;
      if (k <= n && !p.found && mask[c[4:0]]) begin
        p.found = 1'b1;
        p.idx   = c[4:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/qos_tx_holdbuf.sv
// Per-class holding FIFO; a push is accepted while full if a pop happens in the same cycle.
module qos_tx_holdbuf #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qos_tx_injector.sv
// Sender side of the QoS transaction layer: buffers per-class words, round-robins pushes, obeys pause/continue/error strobes.
// Optional weighted bursts are enabled by defining QOS_TX_WEIGHTED_EN (adds WEIGHT_TBL).
module qos_tx_injector
  import qos_tx_pkg::*;
#(
  parameter int NUM_VC     = NUM_VC_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int HOLD_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       SET_INIT,
  input  logic [NUM_VC-1:0]          CLIENT_VALID,
  input  logic [NUM_VC*DATA_W-1:0]   CLIENT_DATA,
  output logic [NUM_VC-1:0]          CLIENT_READY,
  input  logic [NUM_VC-1:0]          PAUSE_STB,
  input  logic [NUM_VC-1:0]          CONTINUE_STB,
  input  logic [NUM_VC-1:0]          ERROR_FULL,
`ifdef QOS_TX_WEIGHTED_EN
  input  logic [NUM_VC*2-1:0]        WEIGHT_TBL,
`endif
  output logic                       PUSHDATOENTRADA,
  output logic [$clog2(NUM_VC)-1:0]  IDINPUT,
  output logic [DATA_W-1:0]          DATO_IN,
  output logic [NUM_VC*CNT_W-1:0]    DROP_CNT,
  output logic [NUM_VC-1:0]          ERR_STICKY,
  output logic                       TX_IDLE
);

  localparam int ID_W = $clog2(NUM_VC);

  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] wr_en;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] paused;
  logic [NUM_VC-1:0] eligible;
  logic [DATA_W-1:0] head [NUM_VC];
  logic [CNT_W-1:0]  drop_cnt [NUM_VC];
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_valid;
  pick_t             pick;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    qos_tx_holdbuf #(
      .DATA_W (DATA_W),
      .DEPTH  (HOLD_DEPTH)
    ) u_buf (
      .clk     (CLOCK),
      .rst     (RESET),
      .wr_en   (wr_en[i]),
      .wr_data (CLIENT_DATA[i*DATA_W +: DATA_W]),
      .rd_en   (pop[i]),
      .rd_data (head[i]),
      .full    (full[i]),
      .empty   (empty[i])
    );
    assign DROP_CNT[i*CNT_W +: CNT_W] = drop_cnt[i];
  end

  // Client handshake: valid/ready both high at the edge transfers a word; ready never looks at valid.
  assign CLIENT_READY = ~full;
  assign wr_en        = CLIENT_VALID & ~full;

  // Same-cycle stop strobes mask the grant so nothing is pushed on the edge that samples them.
  assign eligible = ~empty & ~paused & ~PAUSE_STB & ~ERROR_FULL & {NUM_VC{~SET_INIT}};
  assign TX_IDLE  = (&empty) & ~PUSHDATOENTRADA;

`ifdef QOS_TX_WEIGHTED_EN
  logic [1:0] burst_cnt;
  logic       keep;

  // The last granted class keeps the grant while it stays eligible and has burst credit left.
  assign keep = PUSHDATOENTRADA && eligible[rr_ptr] &&
                (burst_cnt < WEIGHT_TBL[{rr_ptr, 1'b0} +: 2]);

  always_ff @(posedge CLOCK) begin
    if (RESET)            burst_cnt <= '0;
    else if (grant_valid) burst_cnt <= keep ? burst_cnt + 1'b1 : 2'd0;
  end
`endif

  always_comb begin
    pick        = next_eligible(MAX_VC'(eligible), 32'(rr_ptr), NUM_VC);
    grant_valid = pick.found && (pick.idx < 5'(NUM_VC));
    grant_idx   = pick.idx[ID_W-1:0];
`ifdef QOS_TX_WEIGHTED_EN
    if (keep) begin
      grant_valid = 1'b1;
      grant_idx   = rr_ptr;
    end
`endif
    pop = '0;
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      PUSHDATOENTRADA <= 1'b0;
      IDINPUT         <= '0;
      DATO_IN         <= '0;
      rr_ptr          <= ID_W'(NUM_VC - 1);
      paused          <= '0;
      ERR_STICKY      <= '0;
    end else begin
      PUSHDATOENTRADA <= grant_valid;
      if (grant_valid) begin
        IDINPUT <= grant_idx;
        DATO_IN <= head[grant_idx];
        rr_ptr  <= grant_idx;
      end
      // Pause beats continue when both arrive together; init clears everything.
      if (SET_INIT) paused <= '0;
      else          paused <= (paused & ~CONTINUE_STB) | PAUSE_STB | ERROR_FULL;
      ERR_STICKY <= ERR_STICKY | ERROR_FULL;
    end
  end

  always_ff @(posedge CLOCK) begin
    for (int i = 0; i < NUM_VC; i++) begin
      if (RESET)
        drop_cnt[i] <= '0;
      else if (ERROR_FULL[i] && (drop_cnt[i] != {CNT_W{1'b1}}))
        drop_cnt[i] <= drop_cnt[i] + 1'b1;
    end
  end

endmodule

// File: tb/tb_qos_tx_injector.sv
// Directed bench for qos_tx_injector: vector table plus hand-written fill, error-saturation and reset sequences.
module tb_qos_tx_injector;
  import qos_tx_pkg::*;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        SET_INIT;
  logic [3:0]  CLIENT_VALID;
  logic [15:0] CLIENT_DATA;
  logic [3:0]  CLIENT_READY;
  logic [3:0]  PAUSE_STB;
  logic [3:0]  CONTINUE_STB;
  logic [3:0]  ERROR_FULL;
  logic        PUSHDATOENTRADA;
  logic [1:0]  IDINPUT;
  logic [3:0]  DATO_IN;
  logic [31:0] DROP_CNT;
  logic [3:0]  ERR_STICKY;
  logic        TX_IDLE;
`ifdef QOS_TX_WEIGHTED_EN
  logic [7:0]  WEIGHT_TBL = 8'h00;
`endif

  qos_tx_injector dut (
    .CLOCK           (CLOCK),
    .RESET           (RESET),
    .SET_INIT        (SET_INIT),
    .CLIENT_VALID    (CLIENT_VALID),
    .CLIENT_DATA     (CLIENT_DATA),
    .CLIENT_READY    (CLIENT_READY),
    .PAUSE_STB       (PAUSE_STB),
    .CONTINUE_STB    (CONTINUE_STB),
    .ERROR_FULL      (ERROR_FULL),
`ifdef QOS_TX_WEIGHTED_EN
    .WEIGHT_TBL      (WEIGHT_TBL),
`endif
    .PUSHDATOENTRADA (PUSHDATOENTRADA),
    .IDINPUT         (IDINPUT),
    .DATO_IN         (DATO_IN),
    .DROP_CNT        (DROP_CNT),
    .ERR_STICKY      (ERR_STICKY),
    .TX_IDLE         (TX_IDLE)
  );

  // Clock / reset
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] dat;
    logic [3:0]  pse;
    logic [3:0]  cnt;
    logic [3:0]  err;
    logic        si;
    logic        push;
    vc_id_t      id;
    logic [3:0]  dout;
    logic [3:0]  rdy;
    logic        idle;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         n_vec;
  int         n_bad;

  // Driver tasks
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    SET_INIT     = 1'b0;
    CLIENT_VALID = '0;
    CLIENT_DATA  = '0;
    PAUSE_STB    = '0;
    CONTINUE_STB = '0;
    ERROR_FULL   = '0;
  endtask

  task automatic add(input logic [3:0] vld, input logic [15:0] dat, input logic [3:0] pse,
                     input logic [3:0] cnt, input logic [3:0] err, input logic si,
                     input logic push, input logic [1:0] id, input logic [3:0] dout,
                     input logic [3:0] rdy, input logic idle);
    vec_t t;
    t.vld = vld; t.dat = dat; t.pse = pse; t.cnt = cnt; t.err = err; t.si = si;
    t.push = push; t.id = id; t.dout = dout; t.rdy = rdy; t.idle = idle;
    vecs.push_back(t);
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int   npush;
    int   k;
    logic acc;
    logic [3:0] w;

    n_vec = 0;
    n_bad = 0;
    idle_inputs();
    RESET = 1'b1;
    repeat (2) step();
    RESET = 1'b0;

    //   vld   dat       pse   cnt   err  si  push id dout  rdy  idle
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'hf, 1); // reset state
    add(4'h5, 16'h0503, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'hf, 0); // class 0 <- 3, class 2 <- 5
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 0, 4'h3, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 2, 4'h5, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h5, 4'hf, 1);
    add(4'h2, 16'h0090, 4'h2, 4'h0, 4'h0, 0, 0, 2, 4'h5, 4'hf, 0); // class 1 paused on first word
    add(4'h2, 16'h00a0, 4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h5, 4'hd, 0);
    add(4'h2, 16'h00b0, 4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h5, 4'hd, 0); // full, not accepted
    add(4'h0, 16'h0000, 4'h0, 4'h2, 4'h0, 0, 0, 2, 4'h5, 4'hd, 0); // continue
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 1, 4'h9, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 1, 4'ha, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 0, 1, 4'ha, 4'hf, 1);
    add(4'h8, 16'h7000, 4'h8, 4'h8, 4'h0, 0, 0, 1, 4'ha, 4'hf, 0); // pause+continue: pause wins
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 0, 1, 4'ha, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h8, 4'h0, 0, 0, 1, 4'ha, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 3, 4'h7, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 0, 3, 4'h7, 4'hf, 1);
    add(4'h1, 16'h0001, 4'h0, 4'h0, 4'h0, 0, 0, 3, 4'h7, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h1, 4'h0, 4'h0, 0, 0, 3, 4'h7, 4'hf, 0); // stop masks the same edge
    add(4'h0, 16'h0000, 4'h0, 4'h1, 4'h0, 0, 0, 3, 4'h7, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 0, 4'h1, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h1, 4'hf, 1);
    add(4'h4, 16'h0600, 4'h4, 4'h0, 4'h0, 0, 0, 0, 4'h1, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h1, 4'hf, 0); // init clears pause, blocks push
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h1, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 2, 4'h6, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h6, 4'hf, 1);
    add(4'h3, 16'h0021, 4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h6, 4'hf, 0); // two classes alternate
    add(4'h3, 16'h0043, 4'h0, 4'h0, 4'h0, 0, 1, 0, 4'h1, 4'hd, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 1, 4'h2, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 0, 4'h3, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 1, 1, 4'h4, 4'hf, 0);
    add(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h4, 4'hf, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      CLIENT_VALID = vecs[i].vld;
      CLIENT_DATA  = vecs[i].dat;
      PAUSE_STB    = vecs[i].pse;
      CONTINUE_STB = vecs[i].cnt;
      ERROR_FULL   = vecs[i].err;
      SET_INIT     = vecs[i].si;
      step();
      check($sformatf("vec%0d", i),
            {PUSHDATOENTRADA, IDINPUT, DATO_IN, CLIENT_READY, TX_IDLE},
            {vecs[i].push, vecs[i].id, vecs[i].dout, vecs[i].rdy, vecs[i].idle});
    end
    idle_inputs();

    // Class 0 fills while paused, then drains with write+pop overlap; no word may be lost.
    exp_q = {4'h1, 4'h2, 4'h3, 4'h4};
    CLIENT_VALID = 4'h1; CLIENT_DATA = 16'h0001; PAUSE_STB = 4'h1;
    step();
    check("fill_first", {PUSHDATOENTRADA, CLIENT_READY[0]}, 2'b01);
    PAUSE_STB = 4'h0; CLIENT_DATA = 16'h0002;
    step();
    check("fill_full", {PUSHDATOENTRADA, CLIENT_READY[0]}, 2'b00);
    CLIENT_DATA = 16'h0003;
    step();
    check("fill_hold", {PUSHDATOENTRADA, CLIENT_READY[0]}, 2'b00);
    CONTINUE_STB = 4'h1;
    step();
    CONTINUE_STB = 4'h0;
    check("fill_cont_edge", {31'd0, PUSHDATOENTRADA}, 32'd0);
    k = 3;
    for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
      w = 4'(k);
      CLIENT_VALID = (k <= 4) ? 4'h1 : 4'h0;
      CLIENT_DATA  = {12'h000, w};
      acc = CLIENT_VALID[0] & CLIENT_READY[0];
      step();
      if (acc) k++;
      if (PUSHDATOENTRADA) begin
        if (exp_q.size() == 0) check("fill_extra", {62'd0, IDINPUT}, 64'd0);
        else check("fill_order", {IDINPUT, DATO_IN}, {2'd0, exp_q.pop_front()});
      end
    end
    idle_inputs();
    check("fill_drained", 64'(exp_q.size()), 64'd0);
    step();
    check("fill_idle", {63'd0, TX_IDLE}, 64'd1);

    // Error strobes: count saturates, sticky latches, class stays paused.
    ERROR_FULL = 4'h4;
    step();
    check("drop_first", {32'd0, DROP_CNT}, {32'd0, 32'h0001_0000});
    repeat (299) step();
    ERROR_FULL = 4'h0;
    check("drop_sat", {32'd0, DROP_CNT}, {32'd0, 32'h00ff_0000});
    check("err_sticky", {60'd0, ERR_STICKY}, 64'h4);
    CLIENT_VALID = 4'h4; CLIENT_DATA = 16'h0c00;
    step();
    idle_inputs();
    npush = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (PUSHDATOENTRADA) npush++;
    end
    check("err_paused", 64'(npush), 64'd0);
    check("sticky_hold", {60'd0, ERR_STICKY}, 64'h4);

    // Mid-operation reset with a word still buffered.
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("reset_mid",
          {PUSHDATOENTRADA, IDINPUT, DATO_IN, CLIENT_READY, TX_IDLE, ERR_STICKY, DROP_CNT},
          {1'b0, 2'd0, 4'h0, 4'hf, 1'b1, 4'h0, 32'h0});
    npush = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (PUSHDATOENTRADA) npush++;
    end
    check("reset_flush", 64'(npush), 64'd0);
    CLIENT_VALID = 4'h4; CLIENT_DATA = 16'h0d00;
    step();
    idle_inputs();
    step();
    check("post_reset_push", {PUSHDATOENTRADA, IDINPUT, DATO_IN}, {1'b1, 2'd2, 4'hd});

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
